// File: rtl/alu_issue_if.sv
// Bundle of decode-side, forwarding and ALU-side signals around the ID/EX register.
// The master side feeds decode data and consumes the ALU bundle; the slave side is the stage.
interface alu_issue_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [5:0]        in_funct;
  logic [4:0]        in_shamt;
  logic [REG_AW-1:0] in_rs;
  logic [REG_AW-1:0] in_rt;
  logic [REG_AW-1:0] in_rd;
  logic [15:0]       in_imm;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              exmem_wen;
  logic [REG_AW-1:0] exmem_waddr;
  logic [DATA_W-1:0] exmem_wdata;
  logic              memwb_wen;
  logic [REG_AW-1:0] memwb_waddr;
  logic [DATA_W-1:0] memwb_wdata;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [REG_AW-1:0] dest;
  logic              reg_write;
  logic              illegal;

  modport master (
    output in_valid, in_opcode, in_funct, in_shamt, in_rs, in_rt, in_rd, in_imm,
           rs_data, rt_data, exmem_wen, exmem_waddr, exmem_wdata,
           memwb_wen, memwb_waddr, memwb_wdata, flush, out_ready,
    input  in_ready, out_valid, a, b, opcode, funct, shamt, dest, reg_write, illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_funct, in_shamt, in_rs, in_rt, in_rd, in_imm,
           rs_data, rt_data, exmem_wen, exmem_waddr, exmem_wdata,
           memwb_wen, memwb_waddr, memwb_wdata, flush, out_ready,
    output in_ready, out_valid, a, b, opcode, funct, shamt, dest, reg_write, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX register in front of the ALU: forwards operands at capture, builds operand b
// from register or extended immediate, and holds a stable bundle under valid/ready.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SEQI  = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  // Register 0 is hard-wired to zero, so it must never pick up a forwarded value.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_wen,
    input logic [REG_AW-1:0] ex_addr,
    input logic [DATA_W-1:0] ex_data,
    input logic              wb_wen,
    input logic [REG_AW-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] r;
    if (idx == {REG_AW{1'b0}}) begin
      r = {DATA_W{1'b0}};
    end else if (ex_wen && (ex_addr == idx)) begin
      r = ex_data;
    end else if (wb_wen && (wb_addr == idx)) begin
      r = wb_data;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction

  function automatic logic funct_supported(input logic [5:0] f);
    logic r;
    case (f)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b000000, 6'b000001, 6'b000010, 6'b000011,
      6'b011000, 6'b100100, 6'b100101, 6'b100110,
      6'b100111, 6'b101010: r = 1'b1;
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [5:0]        opcode_q, funct_q;
  logic [4:0]        shamt_q;
  logic [REG_AW-1:0] dest_q;
  logic              reg_write_q, illegal_q;

  logic              load_s, xfer_s, legal_s;
  logic [DATA_W-1:0] rs_fwd_s, rt_fwd_s, b_s;
  logic [REG_AW-1:0] dest_s;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load_s       = bus.in_valid && bus.in_ready && !bus.flush;
  assign xfer_s       = valid_q && bus.out_ready;

  assign rs_fwd_s = fwd_operand(bus.in_rs, bus.rs_data, bus.exmem_wen, bus.exmem_waddr,
                                bus.exmem_wdata, bus.memwb_wen, bus.memwb_waddr, bus.memwb_wdata);
  assign rt_fwd_s = fwd_operand(bus.in_rt, bus.rt_data, bus.exmem_wen, bus.exmem_waddr,
                                bus.exmem_wdata, bus.memwb_wen, bus.memwb_waddr, bus.memwb_wdata);

  // Decode operand b, destination and legality from the incoming opcode class.
  always_comb begin
    b_s     = {DATA_W{1'b0}};
    dest_s  = {REG_AW{1'b0}};
    legal_s = 1'b0;
    case (bus.in_opcode)
      OP_RTYPE: begin
        b_s     = rt_fwd_s;
        dest_s  = bus.in_rd;
        legal_s = funct_supported(bus.in_funct);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SEQI: begin
        b_s     = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};
        dest_s  = bus.in_rt;
        legal_s = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        b_s     = {{(DATA_W-16){1'b0}}, bus.in_imm};
        dest_s  = bus.in_rt;
        legal_s = 1'b1;
      end
      default: begin
        b_s     = {DATA_W{1'b0}};
        dest_s  = {REG_AW{1'b0}};
        legal_s = 1'b0;
      end
    endcase
  end

  // Valid next state: flush beats load, load beats transfer.
  always_comb begin
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load_s) begin
      valid_d = 1'b1;
    end else if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload only moves on load, which can never happen while a bundle is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      opcode_q    <= 6'b000000;
      funct_q     <= 6'b000000;
      shamt_q     <= 5'b00000;
      dest_q      <= {REG_AW{1'b0}};
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (load_s) begin
      a_q         <= rs_fwd_s;
      b_q         <= b_s;
      opcode_q    <= bus.in_opcode;
      funct_q     <= bus.in_funct;
      shamt_q     <= bus.in_shamt;
      dest_q      <= dest_s;
      reg_write_q <= legal_s && (dest_s != {REG_AW{1'b0}});
      illegal_q   <= !legal_s;
    end else begin
      a_q         <= a_q;
      b_q         <= b_q;
      opcode_q    <= opcode_q;
      funct_q     <= funct_q;
      shamt_q     <= shamt_q;
      dest_q      <= dest_q;
      reg_write_q <= reg_write_q;
      illegal_q   <= illegal_q;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.opcode    = opcode_q;
  assign bus.funct     = funct_q;
  assign bus.shamt     = shamt_q;
  assign bus.dest      = dest_q;
  assign bus.reg_write = reg_write_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Table-driven bench for alu_issue_stage with a scoreboard queue, plus hand-written
// stall, flush and asynchronous-reset sequences.
module tb_alu_issue_stage;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  alu_issue_if #(.DATA_W(32), .REG_AW(5)) bus ();

  alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rs_data, rt_data;
    logic        exw;
    logic [4:0]  exa;
    logic [31:0] exd;
    logic        mww;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    logic [31:0] ea, eb;
    logic [4:0]  edest;
    logic        erw, eill;
  } vec_t;

  typedef struct packed {
    logic [31:0] a, b;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, dest;
    logic        reg_write, illegal;
  } bundle_t;

  localparam int NV = 16;
  vec_t    vecs[NV];
  bundle_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t actual();
    bundle_t r;
    r = '{bus.a, bus.b, bus.opcode, bus.funct, bus.shamt, bus.dest, bus.reg_write, bus.illegal};
    return r;
  endfunction

  function automatic bundle_t expect_of(input vec_t v);
    bundle_t r;
    r = '{v.ea, v.eb, v.opcode, v.funct, v.shamt, v.edest, v.erw, v.eill};
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.in_opcode   = v.opcode;
    bus.in_funct    = v.funct;
    bus.in_shamt    = v.shamt;
    bus.in_rs       = v.rs;
    bus.in_rt       = v.rt;
    bus.in_rd       = v.rd;
    bus.in_imm      = v.imm;
    bus.rs_data     = v.rs_data;
    bus.rt_data     = v.rt_data;
    bus.exmem_wen   = v.exw;
    bus.exmem_waddr = v.exa;
    bus.exmem_wdata = v.exd;
    bus.memwb_wen   = v.mww;
    bus.memwb_waddr = v.mwa;
    bus.memwb_wdata = v.mwd;
    bus.in_valid    = 1'b1;
  endtask

  initial begin
    // opcode funct shamt rs rt rd imm rs_data rt_data exw exa exd mww mwa mwd | a b dest rw ill
    vecs[0]  = '{6'b000000, 6'b100000, 5'd0, 5'd5, 5'd6, 5'd7, 16'h0000, 32'h10, 32'h11,
                 1'b1, 5'd5, 32'h20, 1'b1, 5'd5, 32'h30, 32'h20, 32'h11, 5'd7, 1'b1, 1'b0};
    vecs[1]  = '{6'b000000, 6'b100000, 5'd0, 5'd5, 5'd6, 5'd7, 16'h0000, 32'h10, 32'h11,
                 1'b0, 5'd5, 32'h20, 1'b1, 5'd5, 32'h30, 32'h30, 32'h11, 5'd7, 1'b1, 1'b0};
    vecs[2]  = '{6'b000000, 6'b100000, 5'd0, 5'd0, 5'd0, 5'd7, 16'h0000, 32'h55, 32'h66,
                 1'b1, 5'd0, 32'h20, 1'b1, 5'd0, 32'h30, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0};
    vecs[3]  = '{6'b000000, 6'b100010, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h1000, 32'h2000,
                 1'b1, 5'd2, 32'hEE, 1'b1, 5'd2, 32'hAB, 32'h1000, 32'hEE, 5'd3, 1'b1, 1'b0};
    vecs[4]  = '{6'b000000, 6'b100100, 5'd0, 5'd4, 5'd2, 5'd8, 16'h0000, 32'h44, 32'h2000,
                 1'b1, 5'd3, 32'hCC, 1'b1, 5'd2, 32'hAB, 32'h44, 32'hAB, 5'd8, 1'b1, 1'b0};
    vecs[5]  = '{6'b001000, 6'b111111, 5'd0, 5'd3, 5'd9, 5'd5, 16'hFFFF, 32'h100, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h100, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0};
    vecs[6]  = '{6'b001101, 6'b000000, 5'd0, 5'd3, 5'd10, 5'd0, 16'hFFFF, 32'h100, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h100, 32'h0000FFFF, 5'd10, 1'b1, 1'b0};
    vecs[7]  = '{6'b001010, 6'b000000, 5'd0, 5'd3, 5'd11, 5'd0, 16'h8000, 32'h100, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h100, 32'hFFFF8000, 5'd11, 1'b1, 1'b0};
    vecs[8]  = '{6'b001100, 6'b000000, 5'd0, 5'd3, 5'd0, 5'd4, 16'h1234, 32'h100, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h100, 32'h00001234, 5'd0, 1'b0, 1'b0};
    vecs[9]  = '{6'b000010, 6'b100000, 5'd0, 5'd3, 5'd0, 5'd0, 16'h1234, 32'h100, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h100, 32'h0, 5'd0, 1'b0, 1'b1};
    vecs[10] = '{6'b000000, 6'b101011, 5'd0, 5'd1, 5'd2, 5'd4, 16'h0000, 32'h1, 32'h2,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1, 32'h2, 5'd4, 1'b0, 1'b1};
    vecs[11] = '{6'b000000, 6'b100000, 5'd0, 5'd1, 5'd2, 5'd0, 16'h0000, 32'h1, 32'h2,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1, 32'h2, 5'd0, 1'b0, 1'b0};
    vecs[12] = '{6'b000000, 6'b000000, 5'd7, 5'd0, 5'd6, 5'd12, 16'h0000, 32'h9, 32'h80,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h80, 5'd12, 1'b1, 1'b0};
    vecs[13] = '{6'b001011, 6'b000000, 5'd0, 5'd3, 5'd13, 5'd0, 16'h7FFF, 32'h100, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h100, 32'h00007FFF, 5'd13, 1'b1, 1'b0};
    vecs[14] = '{6'b001001, 6'b000000, 5'd0, 5'd3, 5'd14, 5'd0, 16'h8001, 32'h100, 32'h0,
                 1'b1, 5'd3, 32'hDEAD, 1'b0, 5'd0, 32'h0, 32'hDEAD, 32'hFFFF8001, 5'd14, 1'b1, 1'b0};
    vecs[15] = '{6'b001110, 6'b000000, 5'd0, 5'd3, 5'd15, 5'd0, 16'h8001, 32'h100, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hBEEF, 32'hBEEF, 32'h00008001, 5'd15, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(vecs[0]);
    bus.in_valid = 1'b0;
    #3;
    check("reset_valid", 128'(bus.out_valid), 128'(1'b0));
    check("reset_bundle", 128'(actual()), 128'(0));
    check("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table: expected bundle queued at drive time, popped when the DUT presents it.
    for (int i = 0; i < NV; i++) begin
      int n;
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(expect_of(vecs[i]));
      check($sformatf("vec%0d_in_ready", i), 128'(bus.in_ready), 128'(1'b1));
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!(bus.out_valid && bus.out_ready) && n < 4);
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("vec%0d_latency", i), 128'(n), 128'(1));
        check($sformatf("vec%0d_bundle", i), 128'(actual()), 128'(sb.pop_front()));
      end else begin
        check($sformatf("vec%0d_timeout", i), 128'(bus.out_valid), 128'(1'b1));
        void'(sb.pop_front());
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", 128'(bus.out_valid), 128'(1'b0));

    // Stall: A is held bit-stable while B waits, then B loads on the release cycle.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check("stall_A_valid", 128'(bus.out_valid), 128'(1'b1));
    check("stall_A_bundle", 128'(actual()), 128'(expect_of(vecs[0])));
    @(negedge clk);
    drive(vecs[5]);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_hold%0d_bundle", c), 128'(actual()), 128'(expect_of(vecs[0])));
      check($sformatf("stall_hold%0d_in_ready", c), 128'(bus.in_ready), 128'(1'b0));
      check($sformatf("stall_hold%0d_valid", c), 128'(bus.out_valid), 128'(1'b1));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    check("stall_B_valid", 128'(bus.out_valid), 128'(1'b1));
    check("stall_B_bundle", 128'(actual()), 128'(expect_of(vecs[5])));
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stall_drain_valid", 128'(bus.out_valid), 128'(1'b0));

    // Flush while stalled, then flush with an accepting stage: nothing is captured.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(vecs[6]);
    @(posedge clk);
    #1;
    check("flush_pre_valid", 128'(bus.out_valid), 128'(1'b1));
    @(negedge clk);
    drive(vecs[7]);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready_stalled", 128'(bus.in_ready), 128'(1'b0));
    @(posedge clk);
    #1;
    check("flush_kill_valid", 128'(bus.out_valid), 128'(1'b0));
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("flush_in_ready_idle", 128'(bus.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    check("flush_drop_valid", 128'(bus.out_valid), 128'(1'b0));
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("flush_after_valid", 128'(bus.out_valid), 128'(1'b0));

    // Asynchronous reset mid-stall clears outputs without a clock edge.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(vecs[14]);
    @(posedge clk);
    #1;
    check("areset_pre_valid", 128'(bus.out_valid), 128'(1'b1));
    check("areset_pre_a", 128'(bus.a), 128'(32'hDEAD));
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", 128'(bus.out_valid), 128'(1'b0));
    check("areset_ab", 128'({bus.a, bus.b}), 128'(64'h0));
    check("areset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(vecs[12]);
    #1;
    check("areset_release_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    check("areset_first_load_valid", 128'(bus.out_valid), 128'(1'b1));
    check("areset_first_load_bundle", 128'(actual()), 128'(expect_of(vecs[12])));
    @(negedge clk);
    bus.in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
